// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer width and elaboration-time configuration checks.
package fifo_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

  // DEPTH must be a power of two >= 2 and AE_LEVEL < AF_LEVEL <= DEPTH.
  function automatic bit params_ok(input int unsigned depth,
                                   input int unsigned af_level,
                                   input int unsigned ae_level);
    return (depth >= 32'd2) && ((depth & (depth - 32'd1)) == 32'd0) &&
           (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ptr_w(DEPTH)-2:0]      waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [ptr_w(DEPTH)-2:0]      raddr,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syncfifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags and optional FWFT read.
module syncfifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wen,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      ren,
  output logic [WIDTH-1:0]          rdata,
  output logic                      valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow,
  output logic [ptr_w(DEPTH)-1:0]   count
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_cfg
    $error("syncfifo_param: DEPTH must be a power of two >= 2 and AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW-1:0]    wptr_n, rptr_n, cnt_n;
  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] mem_rd;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok  = ren && !empty;
    wr_ok  = wen && (!full || rd_ok);
    wptr_n = wptr_q + PW'(wr_ok);
    rptr_n = rptr_q + PW'(rd_ok);
    cnt_n  = wptr_n - rptr_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr_q       <= wptr_n;
      rptr_q       <= rptr_n;
      count        <= cnt_n;
      full         <= (cnt_n == PW'(DEPTH));
      empty        <= (cnt_n == '0);
      almost_full  <= (cnt_n >= PW'(AF_LEVEL));
      almost_empty <= (cnt_n <= PW'(AE_LEVEL));
      overflow     <= wen && !wr_ok;
      underflow    <= ren && !rd_ok;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[AW-1:0]),
    .rdata (mem_rd)
  );

  if (FWFT) begin : g_fwft
    // Head word is presented directly; masked to zero while empty so reset shows rdata=0.
    always_comb begin
      valid = !empty;
      rdata = empty ? '0 : mem_rd;
    end
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata <= '0;
        valid <= 1'b0;
      end else begin
        valid <= rd_ok;
        if (rd_ok) rdata <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_syncfifo_param.sv
// Scoreboard bench for syncfifo_param: FWFT=0 depth 16, FWFT=1 depth 16, FWFT=0 depth 4.
module tb_syncfifo_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT 0: WIDTH=8 DEPTH=16 AF=14 AE=2 FWFT=0
  logic       wen0 = 0, ren0 = 0;
  logic [7:0] wdata0 = 0, rdata0;
  logic       valid0, full0, empty0, af0, ae0, ov0, un0;
  logic [4:0] count0;
  // DUT 1: same sizes, FWFT=1
  logic       wen1 = 0, ren1 = 0;
  logic [7:0] wdata1 = 0, rdata1;
  logic       valid1, full1, empty1, af1, ae1, ov1, un1;
  logic [4:0] count1;
  // DUT 2: DEPTH=4 AF=3 AE=1 FWFT=0
  logic       wen2 = 0, ren2 = 0;
  logic [7:0] wdata2 = 0, rdata2;
  logic       valid2, full2, empty2, af2, ae2, ov2, un2;
  logic [2:0] count2;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  syncfifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wen(wen0), .wdata(wdata0), .ren(ren0), .rdata(rdata0),
    .valid(valid0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ov0), .underflow(un0), .count(count0));

  syncfifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wen(wen1), .wdata(wdata1), .ren(ren1), .rdata(rdata1),
    .valid(valid1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ov1), .underflow(un1), .count(count1));

  syncfifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wen(wen2), .wdata(wdata2), .ren(ren2), .rdata(rdata2),
    .valid(valid2), .full(full2), .empty(empty2), .almost_full(af2), .almost_empty(ae2),
    .overflow(ov2), .underflow(un2), .count(count2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop expected word whenever a DUT presents read data.
  always @(negedge clk) begin
    if (valid0) begin
      if (q0.size() == 0) check("rd0_unexpected", 32'(rdata0), 32'hFFFF_FFFF);
      else check("rd0_data", 32'(rdata0), 32'(q0.pop_front()));
    end
    if (valid1 && ren1) begin
      if (q1.size() == 0) check("rd1_unexpected", 32'(rdata1), 32'hFFFF_FFFF);
      else check("rd1_data", 32'(rdata1), 32'(q1.pop_front()));
    end
    if (valid2) begin
      if (q2.size() == 0) check("rd2_unexpected", 32'(rdata2), 32'hFFFF_FFFF);
      else check("rd2_data", 32'(rdata2), 32'(q2.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mcnt;
    logic w, r, wok, rok;
    logic [7:0] d;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count0), 0);
    check("rst_empty", 32'(empty0), 1);
    check("rst_ae", 32'(ae0), 1);
    check("rst_full", 32'(full0), 0);
    check("rst_af", 32'(af0), 0);
    check("rst_ov", 32'(ov0), 0);
    check("rst_un", 32'(un0), 0);
    check("rst_valid", 32'(valid0), 0);
    check("rst_rdata", 32'(rdata0), 0);
    check("rst_valid_fwft", 32'(valid1), 0);
    rst_n = 1'b1;

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wen0 = 1; wdata0 = 8'(i); q0.push_back(8'(i));
      cyc();
      check("fill_count", 32'(count0), 32'(i));
      check("fill_af", 32'(af0), 32'(i >= 14));
      check("fill_full", 32'(full0), 32'(i == 16));
      check("fill_ae", 32'(ae0), 32'(i <= 2));
    end
    wdata0 = 8'hAA;
    cyc();
    wen0 = 0;
    check("ovf_pulse", 32'(ov0), 1);
    check("ovf_count", 32'(count0), 16);
    cyc();
    check("ovf_clear", 32'(ov0), 0);

    // Drain back-to-back
    ren0 = 1;
    repeat (16) cyc();
    ren0 = 0;
    check("drain_count", 32'(count0), 0);
    check("drain_empty", 32'(empty0), 1);
    check("drain_valid_last", 32'(valid0), 1);
    ren0 = 1;
    cyc();
    ren0 = 0;
    check("udf_pulse", 32'(un0), 1);
    check("udf_valid", 32'(valid0), 0);
    cyc();
    check("udf_clear", 32'(un0), 0);

    // Simultaneous write+read at full
    for (int i = 0; i < 16; i++) begin
      wen0 = 1; wdata0 = 8'(8'h21 + i); q0.push_back(8'(8'h21 + i));
      cyc();
    end
    wen0 = 1; ren0 = 1; wdata0 = 8'h55; q0.push_back(8'h55);
    cyc();
    wen0 = 0;
    check("full_rw_ov", 32'(ov0), 0);
    check("full_rw_count", 32'(count0), 16);
    repeat (16) cyc();
    ren0 = 0;
    check("full_rw_drained", 32'(count0), 0);

    // Simultaneous write+read at empty
    wen0 = 1; ren0 = 1; wdata0 = 8'h77; q0.push_back(8'h77);
    cyc();
    wen0 = 0; ren0 = 0;
    check("empty_rw_un", 32'(un0), 1);
    check("empty_rw_count", 32'(count0), 1);
    check("empty_rw_valid", 32'(valid0), 0);
    ren0 = 1;
    cyc();
    ren0 = 0;
    cyc();

    // FWFT: head visible without ren
    wen1 = 1; wdata1 = 8'h3C; q1.push_back(8'h3C);
    cyc();
    wen1 = 0;
    check("fwft_valid", 32'(valid1), 1);
    check("fwft_rdata", 32'(rdata1), 32'h3C);
    ren1 = 1;
    cyc();
    ren1 = 0;
    check("fwft_pop_valid", 32'(valid1), 0);
    check("fwft_pop_empty", 32'(empty1), 1);
    wen1 = 1; wdata1 = 8'hA1; q1.push_back(8'hA1);
    cyc();
    wdata1 = 8'hB2; q1.push_back(8'hB2);
    cyc();
    wen1 = 0;
    check("fwft_head2", 32'(rdata1), 32'hA1);
    ren1 = 1;
    repeat (2) cyc();
    ren1 = 0;
    check("fwft_drained", 32'(count1), 0);

    // Wrap-around on DEPTH=4 with a reference occupancy model
    mcnt = 0;
    for (int i = 0; i < 40; i++) begin
      w = (i < 20) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = (i < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      rok = r && (mcnt > 0);
      wok = w && ((mcnt < 4) || rok);
      wen2 = w; ren2 = r; wdata2 = d;
      if (wok) q2.push_back(d);
      mcnt = mcnt + int'(wok) - int'(rok);
      cyc();
      check("wrap_count", 32'(count2), 32'(mcnt));
      check("wrap_ovf", 32'(ov2), 32'(w && !wok));
      check("wrap_full", 32'(full2), 32'(mcnt == 4));
    end
    wen2 = 0; ren2 = 1;
    repeat (5) cyc();
    ren2 = 0;
    cyc();
    check("wrap_drained", 32'(count2), 0);

    // Asynchronous reset mid-burst at count=9
    for (int i = 0; i < 9; i++) begin
      wen0 = 1; wdata0 = 8'(8'h90 + i);
      cyc();
    end
    wen0 = 0;
    check("burst_count", 32'(count0), 9);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count0), 0);
    check("async_rst_empty", 32'(empty0), 1);
    #1 rst_n = 1'b1;
    cyc();
    check("post_rst_count", 32'(count0), 0);

    check("q0_left", 32'(q0.size()), 0);
    check("q1_left", 32'(q1.size()), 0);
    check("q2_left", 32'(q2.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
